// File: rtl/stack_pointer_unit.sv
// Stack pointer / occupancy tracker for PUSH/POP in EXE; issues one registered
// word address per stack operation to MEM and parks in ERR on overflow, underflow or push+pop.
module stack_pointer_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = 32'h0000_0400,
  parameter int unsigned           STACK_DEPTH = 64,
  parameter int unsigned           WORD_BYTES  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid_in,
  input  logic                               push_in,
  input  logic                               pop_in,
  input  logic                               freeze,
  input  logic                               flush,
  input  logic                               err_clear,
  output logic [ADDR_WIDTH-1:0]              sp,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic                               mem_op_valid,
  output logic                               mem_op_push,
  output logic                               ovf,
  output logic                               udf,
  output logic                               illegal,
  output logic                               err
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0]         FULL = DW'(STACK_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WORD_BYTES);

  typedef enum logic {RUN, ERR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_op_valid_q, mem_op_valid_d;
  logic                  mem_op_push_q, mem_op_push_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  illegal_q, illegal_d;
  logic                  req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      sp_q           <= STACK_BASE;
      depth_q        <= '0;
      mem_addr_q     <= '0;
      mem_op_valid_q <= 1'b0;
      mem_op_push_q  <= 1'b0;
      ovf_q          <= 1'b0;
      udf_q          <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sp_q           <= sp_d;
      depth_q        <= depth_d;
      mem_addr_q     <= mem_addr_d;
      mem_op_valid_q <= mem_op_valid_d;
      mem_op_push_q  <= mem_op_push_d;
      ovf_q          <= ovf_d;
      udf_q          <= udf_d;
      illegal_q      <= illegal_d;
    end
  end

  always_comb begin
    req            = valid_in & (push_in | pop_in);
    state_d        = state_q;
    sp_d           = sp_q;
    depth_d        = depth_q;
    mem_addr_d     = mem_addr_q;
    mem_op_valid_d = mem_op_valid_q;
    mem_op_push_d  = mem_op_push_q;
    ovf_d          = ovf_q;
    udf_d          = udf_q;
    illegal_d      = illegal_q;

    // Flush outranks freeze: it kills the pending MEM op even when stalled.
    if (flush) begin
      mem_op_valid_d = 1'b0;
    end else if (!freeze) begin
      mem_op_valid_d = 1'b0;
      unique case (state_q)
        RUN: begin
          if (req) begin
            if (push_in && pop_in) begin
              illegal_d = 1'b1;
              state_d   = ERR;
            end else if (push_in) begin
              if (depth_q == FULL) begin
                ovf_d   = 1'b1;
                state_d = ERR;
              end else begin
                sp_d           = sp_q - STEP;
                mem_addr_d     = sp_q - STEP;
                mem_op_push_d  = 1'b1;
                mem_op_valid_d = 1'b1;
                depth_d        = depth_q + DW'(1);
              end
            end else begin
              if (depth_q == '0) begin
                udf_d   = 1'b1;
                state_d = ERR;
              end else begin
                sp_d           = sp_q + STEP;
                mem_addr_d     = sp_q;
                mem_op_push_d  = 1'b0;
                mem_op_valid_d = 1'b1;
                depth_d        = depth_q - DW'(1);
              end
            end
          end
        end
        ERR: begin
          if (err_clear) begin
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
            illegal_d = 1'b0;
            state_d   = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign sp           = sp_q;
  assign depth        = depth_q;
  assign mem_addr     = mem_addr_q;
  assign mem_op_valid = mem_op_valid_q;
  assign mem_op_push  = mem_op_push_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;
  assign illegal      = illegal_q;
  assign err          = (state_q == ERR);

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Scoreboard bench for stack_pointer_unit: expected MEM ops are queued at issue
// time and a negedge monitor pops one entry per cycle that mem_op_valid is high.
module tb_stack_pointer_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, push_in, pop_in, freeze, flush, err_clear;
  logic [31:0] sp, mem_addr;
  logic [6:0]  depth;
  logic        mem_op_valid, mem_op_push, ovf, udf, illegal, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        push;
  } exp_t;
  exp_t exp_q[$];

  stack_pointer_unit #(
    .ADDR_WIDTH (32),
    .STACK_BASE (32'h0000_0400),
    .STACK_DEPTH(64),
    .WORD_BYTES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .push_in     (push_in),
    .pop_in      (pop_in),
    .freeze      (freeze),
    .flush       (flush),
    .err_clear   (err_clear),
    .sp          (sp),
    .depth       (depth),
    .mem_addr    (mem_addr),
    .mem_op_valid(mem_op_valid),
    .mem_op_push (mem_op_push),
    .ovf         (ovf),
    .udf         (udf),
    .illegal     (illegal),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_op(input logic [31:0] a, input logic p, input int unsigned n = 1);
    exp_t e;
    e.addr = a;
    e.push = p;
    for (int unsigned k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  // One clock: drive inputs, let the edge happen, return at the following negedge.
  task automatic cyc(input logic v, input logic pu, input logic po,
                     input logic fr, input logic fl, input logic ec);
    valid_in  = v;
    push_in   = pu;
    pop_in    = po;
    freeze    = fr;
    flush     = fl;
    err_clear = ec;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    valid_in = 0; push_in = 0; pop_in = 0; freeze = 0; flush = 0; err_clear = 0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && mem_op_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_mem_op", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_mem_addr", mem_addr, e.addr);
        chk("mon_mem_op_push", {31'b0, mem_op_push}, {31'b0, e.push});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] push_tab [3];
    logic [31:0] pop_tab  [3];
    push_tab = '{32'h3FC, 32'h3F8, 32'h3F4};
    pop_tab  = '{32'h3F4, 32'h3F8, 32'h3FC};

    rst = 1'b0;
    valid_in = 0; push_in = 0; pop_in = 0; freeze = 0; flush = 0; err_clear = 0;
    repeat (2) @(negedge clk);
    chk("rst_sp", sp, 32'h400);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_flags", {26'b0, mem_op_valid, mem_op_push, ovf, udf, illegal, err}, 32'd0);
    rst = 1'b1;

    // Three pushes then three pops, back to back.
    for (int i = 0; i < 3; i++) begin
      expect_op(push_tab[i], 1'b1);
      cyc(1, 1, 0, 0, 0, 0);
    end
    chk("p3_sp", sp, 32'h3F4);
    chk("p3_depth", 32'(depth), 32'd3);
    for (int i = 0; i < 3; i++) begin
      expect_op(pop_tab[i], 1'b0);
      cyc(1, 0, 1, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("pp_sp", sp, 32'h400);
    chk("pp_depth", 32'(depth), 32'd0);
    chk("pp_valid_low", {31'b0, mem_op_valid}, 32'd0);

    // Fill to 64, overflow, clear, pop.
    for (int i = 0; i < 64; i++) begin
      expect_op(32'h400 - 32'(4 * (i + 1)), 1'b1);
      cyc(1, 1, 0, 0, 0, 0);
    end
    chk("full_depth", 32'(depth), 32'd64);
    chk("full_sp", sp, 32'h300);
    cyc(1, 1, 0, 0, 0, 0);
    chk("ovf_flag", {31'b0, ovf}, 32'd1);
    chk("ovf_err", {31'b0, err}, 32'd1);
    chk("ovf_valid", {31'b0, mem_op_valid}, 32'd0);
    chk("ovf_sp", sp, 32'h300);
    chk("ovf_depth", 32'(depth), 32'd64);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ovf_sticky", {31'b0, ovf}, 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr_err", {31'b0, err}, 32'd0);
    chk("clr_ovf", {31'b0, ovf}, 32'd0);
    chk("clr_sp", sp, 32'h300);
    expect_op(32'h300, 1'b0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("pop_after_clr_sp", sp, 32'h304);
    chk("pop_after_clr_depth", 32'(depth), 32'd63);
    cyc(0, 0, 0, 0, 0, 0);

    // Underflow, requests ignored in ERR, request with err_clear ignored.
    do_reset();
    cyc(1, 0, 1, 0, 0, 0);
    chk("udf_flag", {31'b0, udf}, 32'd1);
    chk("udf_err", {31'b0, err}, 32'd1);
    chk("udf_sp", sp, 32'h400);
    cyc(1, 1, 0, 0, 0, 0);
    chk("err_ignore_depth", 32'(depth), 32'd0);
    chk("err_ignore_valid", {31'b0, mem_op_valid}, 32'd0);
    cyc(1, 1, 0, 0, 0, 1);
    chk("clr_with_req_err", {31'b0, err}, 32'd0);
    chk("clr_with_req_udf", {31'b0, udf}, 32'd0);
    chk("clr_with_req_depth", 32'(depth), 32'd0);
    expect_op(32'h3FC, 1'b1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("post_clr_push_sp", sp, 32'h3FC);

    // valid_in masking, then illegal push+pop.
    cyc(0, 1, 0, 0, 0, 0);
    chk("mask_depth", 32'(depth), 32'd1);
    cyc(1, 1, 1, 0, 0, 0);
    chk("illegal_flag", {31'b0, illegal}, 32'd1);
    chk("illegal_err", {31'b0, err}, 32'd1);
    chk("illegal_depth", 32'(depth), 32'd1);
    chk("illegal_sp", sp, 32'h3FC);
    cyc(0, 0, 0, 0, 0, 1);
    chk("illegal_clr", {31'b0, illegal}, 32'd0);

    // Freeze holds the previous pulse and blocks the new push for 3 cycles.
    expect_op(32'h3F8, 1'b1, 4);
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 1, 0, 0);
      chk("frz_sp", sp, 32'h3F8);
      chk("frz_depth", 32'(depth), 32'd2);
    end
    expect_op(32'h3F4, 1'b1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("unfrz_sp", sp, 32'h3F4);
    chk("unfrz_depth", 32'(depth), 32'd3);
    cyc(0, 0, 0, 0, 0, 0);

    // Flush kills the request, with and without freeze.
    cyc(1, 1, 0, 0, 1, 0);
    chk("flush_sp", sp, 32'h3F4);
    chk("flush_valid", {31'b0, mem_op_valid}, 32'd0);
    expect_op(32'h3F0, 1'b1);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 1, 0);
    chk("flush_frz_valid", {31'b0, mem_op_valid}, 32'd0);
    chk("flush_frz_sp", sp, 32'h3F0);
    chk("flush_frz_depth", 32'(depth), 32'd4);
    cyc(0, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges, right after a push is accepted.
    valid_in = 1; push_in = 1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_sp", sp, 32'h400);
    chk("arst_depth", 32'(depth), 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_flags", {26'b0, mem_op_valid, mem_op_push, ovf, udf, illegal, err}, 32'd0);
    valid_in = 0; push_in = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
